// File: rtl/fifo_rd_stream_pkg.sv
// Shared types for the FIFO read-side stream consumer.
// The occupancy encoding equals the number of buffered words.
package fifo_rd_stream_pkg;

  localparam int unsigned LEVEL_W = 2;

  typedef enum logic [LEVEL_W-1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  // Number of words held for a given occupancy state
  function automatic logic [LEVEL_W-1:0] occ_level(input occ_e occ);
    return LEVEL_W'(occ);
  endfunction

endpackage

// File: rtl/fifo_rd_stream_skid_buf2.sv
// Two-entry register buffer; entry 0 is always the oldest word and drives o_data.
// A push with a simultaneous pop in ONE replaces entry 0 directly.
module fifo_rd_stream_skid_buf2
  import fifo_rd_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  input  logic                  i_pop,
  input  logic                  i_flush,
  output occ_e                  o_occ,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data
);

  occ_e                  r_occ;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_entry0;
  logic [DATA_WIDTH-1:0] r_entry1;

  // Occupancy FSM with entry shifting; flush keeps stale data but drops validity
  always_ff @(posedge clk) begin
    if (rst) begin
      r_occ    <= OCC_EMPTY;
      r_valid  <= 1'b0;
      r_entry0 <= '0;
      r_entry1 <= '0;
    end else if (i_flush) begin
      r_occ   <= OCC_EMPTY;
      r_valid <= 1'b0;
    end else begin
      case (r_occ)
        OCC_EMPTY: begin
          if (i_push) begin
            r_entry0 <= i_push_data;
            r_occ    <= OCC_ONE;
            r_valid  <= 1'b1;
          end
        end
        OCC_ONE: begin
          if (i_push && i_pop) begin
            r_entry0 <= i_push_data;
          end else if (i_push) begin
            r_entry1 <= i_push_data;
            r_occ    <= OCC_TWO;
          end else if (i_pop) begin
            r_occ   <= OCC_EMPTY;
            r_valid <= 1'b0;
          end
        end
        OCC_TWO: begin
          if (i_pop) begin
            r_entry0 <= r_entry1;
            if (i_push) begin
              r_entry1 <= i_push_data;
            end else begin
              r_occ <= OCC_ONE;
            end
          end
        end
        default: begin
          r_occ   <= OCC_EMPTY;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_occ   = r_occ;
  assign o_valid = r_valid;
  assign o_data  = r_entry0;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side consumer of the async FIFO: pops words and presents them as a
// valid/ready stream, hiding the FIFO's registered read latency.
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  input  logic                  flush,
  output logic [CNT_WIDTH-1:0]  rd_count
);

  occ_e                 w_occ;
  logic                 w_pop;
  logic                 w_issue;
  logic                 w_push;
  logic [2:0]           w_level_pre;
  logic [2:0]           w_level_post;
  logic                 r_inflight;
  logic [CNT_WIDTH-1:0] r_count;

  assign w_pop = m_valid & m_ready;

  // Committed words (buffered + in flight) after this cycle's pop; never exceeds 2
  assign w_level_pre  = 3'(occ_level(w_occ)) + 3'(r_inflight);
  assign w_level_post = w_level_pre - 3'(w_pop);

  // Combinational from m_ready so a ready sink sustains one word per cycle
  assign fifo_rd_en = ~rrst & ~flush & ~fifo_empty & (w_level_post < 3'd2);
  assign w_issue    = fifo_rd_en & ~fifo_empty;
  assign w_push     = r_inflight & ~flush;

  always_ff @(posedge rclk) begin
    if (rrst) begin
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
    end
  end

  // Delivered-word counter, wraps naturally; a pop during flush still counts
  always_ff @(posedge rclk) begin
    if (rrst) begin
      r_count <= '0;
    end else if (w_pop) begin
      r_count <= r_count + CNT_WIDTH'(1);
    end
  end

  assign rd_count = r_count;

  fifo_rd_stream_skid_buf2 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk         (rclk),
    .rst         (rrst),
    .i_push      (w_push),
    .i_push_data (fifo_data),
    .i_pop       (w_pop),
    .i_flush     (flush),
    .o_occ       (w_occ),
    .o_valid     (m_valid),
    .o_data      (m_data)
  );

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench: a FIFO model feeds the DUT, popped words are queued as
// expected stream output and a negedge monitor checks every accepted word.
module tb_fifo_rd_stream;

  localparam int unsigned DW   = 8;
  localparam int unsigned CW   = 16;
  localparam int unsigned CW_S = 4;

  logic          rclk = 1'b0;
  logic          rrst;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data;
  logic          flush;
  logic          m_ready;

  logic            fifo_rd_en, fifo_rd_en_s;
  logic            m_valid, m_valid_s;
  logic [DW-1:0]   m_data, m_data_s;
  logic [CW-1:0]   rd_count;
  logic [CW_S-1:0] rd_count_s;

  fifo_rd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) u_dut (
    .rclk(rclk), .rrst(rrst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd_en(fifo_rd_en), .m_valid(m_valid), .m_data(m_data),
    .m_ready(m_ready), .flush(flush), .rd_count(rd_count)
  );

  // Narrow-counter instance on the same stimulus, used for the wrap check
  fifo_rd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(CW_S)) u_dut_s (
    .rclk(rclk), .rrst(rrst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd_en(fifo_rd_en_s), .m_valid(m_valid_s), .m_data(m_data_s),
    .m_ready(m_ready), .flush(flush), .rd_count(rd_count_s)
  );

  always #5 rclk = ~rclk;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  int            pend       = 0;
  int            inflight_m = 0;
  bit            mon_en     = 1'b0;

  int cyc = 0, first_iss = -1, first_del = -1, last_del = -1, del_n = 0;

  task automatic check(input bit ok, input string name, input longint act, input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h @%0t", name, act, req, $time);
    end
  endtask

  // Monitor: compares accepted words, stall stability and the delivered count
  logic [CW-1:0] cnt_m = '0;
  bit            hold_prev = 1'b0;
  logic [DW-1:0] data_prev = '0;
  logic [DW-1:0] mon_exp;

  always @(negedge rclk) begin
    if (mon_en) begin
      check(rd_count == cnt_m, "rd_count", rd_count, cnt_m);
      check(rd_count_s == cnt_m[CW_S-1:0], "rd_count_wrap", rd_count_s, cnt_m[CW_S-1:0]);
      if (hold_prev)
        check(m_valid && (m_data == data_prev), "stall_hold", {m_valid, m_data}, {1'b1, data_prev});
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_word", m_data, 0);
        end else begin
          mon_exp = exp_q.pop_front();
          check(m_data == mon_exp, "m_data", m_data, mon_exp);
        end
      end
      hold_prev = m_valid && !m_ready && !flush && !rrst;
      data_prev = m_data;
      if (rrst) cnt_m = '0;
      else if (m_valid && m_ready) cnt_m = cnt_m + CW'(1);
    end
  end

  task automatic stats_clear();
    cyc = 0; first_iss = -1; first_del = -1; last_del = -1; del_n = 0;
  endtask

  // One clock cycle: apply inputs, check valid/rd_en against the model, update FIFO model
  task automatic step(input bit rst, input bit fl, input bit rdy, input bit gate);
    logic [DW-1:0] w;
    bit            iss;
    bit            exp_valid;
    bit            exp_rd_en;
    int            pop_n;
    rrst       = rst;
    flush      = fl;
    m_ready    = rdy;
    fifo_empty = (fifo_q.size() == 0) || gate;
    @(negedge rclk); #1;
    exp_valid = (pend - inflight_m) > 0;
    pop_n     = (exp_valid && rdy) ? 1 : 0;
    exp_rd_en = !rst && !fl && !fifo_empty && ((pend - pop_n) < 2);
    check(fifo_rd_en == exp_rd_en, "fifo_rd_en", fifo_rd_en, exp_rd_en);
    if (mon_en) check(m_valid == exp_valid, "m_valid", m_valid, exp_valid);
    iss = fifo_rd_en && !fifo_empty;
    w   = '0;
    if (iss && fifo_q.size() > 0) w = fifo_q.pop_front();
    if (fl || rst) exp_q.delete();
    if (iss && !rst) exp_q.push_back(w);
    if (mon_en) check(exp_q.size() <= 2, "occ_plus_inflight", exp_q.size(), 2);
    if (iss && first_iss < 0) first_iss = cyc;
    if (mon_en && m_valid && rdy) begin
      if (first_del < 0) first_del = cyc;
      last_del = cyc;
      del_n++;
    end
    inflight_m = (iss && !rst) ? 1 : 0;
    pend       = exp_q.size();
    cyc++;
    if (rst) mon_en = 1'b1;
    @(posedge rclk); #1;
    fifo_data = iss ? w : DW'($urandom);
  endtask

  initial begin
    rrst = 1'b1; flush = 1'b0; m_ready = 1'b0; fifo_empty = 1'b1; fifo_data = '0;

    // Reset with a non-empty FIFO, then stream 0x11..0x18 with a ready sink
    for (int i = 0; i < 8; i++) fifo_q.push_back(DW'(32'h11 + i));
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    check(m_valid == 1'b0, "reset_valid", m_valid, 0);
    check(m_data == '0, "reset_data", m_data, 0);
    check(rd_count == '0, "reset_count", rd_count, 0);
    stats_clear();
    repeat (12) step(1'b0, 1'b0, 1'b1, 1'b0);
    check(del_n == 8, "stream_words", del_n, 8);
    check(last_del - first_del == 7, "stream_gapless", last_del - first_del, 7);
    check(first_del - first_iss == 2, "stream_latency", first_del - first_iss, 2);
    check(rd_count == 16'd8, "stream_count", rd_count, 8);

    // Backpressure: stall five cycles then release
    for (int i = 0; i < 4; i++) fifo_q.push_back(DW'(32'hA0 + i));
    repeat (5) step(1'b0, 1'b0, 1'b0, 1'b0);
    check(m_valid && (m_data == 8'hA0), "bp_head", {m_valid, m_data}, {1'b1, 8'hA0});
    repeat (8) step(1'b0, 1'b0, 1'b1, 1'b0);
    check(rd_count == 16'd12, "bp_count", rd_count, 12);

    // Alternating ready
    for (int i = 0; i < 6; i++) fifo_q.push_back(DW'(32'hB0 + i));
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, (i % 2) == 0, 1'b0);
    check(rd_count == 16'd18, "alt_count", rd_count, 18);

    // Flush with 0x02 buffered and 0x03 arriving; 0x04 must follow
    for (int i = 1; i <= 5; i++) fifo_q.push_back(DW'(i));
    repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check(m_valid == 1'b0, "flush_valid", m_valid, 0);
    repeat (6) step(1'b0, 1'b0, 1'b1, 1'b0);
    check(rd_count == 16'd21, "flush_count", rd_count, 21);

    // Counter wrap on the narrow instance
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 17; i++) fifo_q.push_back(DW'($urandom));
    repeat (22) step(1'b0, 1'b0, 1'b1, 1'b0);
    check(rd_count_s == 4'd1, "wrap_count", rd_count_s, 1);
    check(rd_count == 16'd17, "wrap_full_count", rd_count, 17);

    // Randomized traffic with stalls, empty gaps, flushes and resets
    for (int i = 0; i < 1200; i++) begin
      if ($urandom_range(0, 99) < 45 && fifo_q.size() < 20) fifo_q.push_back(DW'($urandom));
      step($urandom_range(0, 299) == 0, $urandom_range(0, 99) < 3,
           $urandom_range(0, 99) < 65, $urandom_range(0, 99) < 15);
    end
    repeat (30) step(1'b0, 1'b0, 1'b1, 1'b0);
    check(exp_q.size() == 0, "drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
